// File: rtl/ddr2_ex_lfsr_gen_chk_if.sv
// ---------------------------------------------------------------------------
// ddr2_ex_lfsr_gen_chk_if
// Bundle of control, check-data and status signals for one LFSR
// generator/checker instance.
//   master : the side that drives mode/control and check data, reads status
//   slave  : the LFSR generator/checker itself
// Signals:
//   enable, pause, load, ldata       generator control
//   chk_en, chk_valid, chk_data      checker mode select and received words
//   clr_err, inject_err              error status clear / error injection
//   data, locked, err_sticky,
//   err_count, first_err_xor         registered outputs
// ---------------------------------------------------------------------------
interface ddr2_ex_lfsr_gen_chk_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) ();
  logic                 enable;
  logic                 pause;
  logic                 load;
  logic [WIDTH-1:0]     ldata;
  logic                 chk_en;
  logic                 chk_valid;
  logic [WIDTH-1:0]     chk_data;
  logic                 clr_err;
  logic                 inject_err;
  logic [WIDTH-1:0]     data;
  logic                 locked;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     first_err_xor;

  modport master (
    output enable, pause, load, ldata, chk_en, chk_valid, chk_data,
           clr_err, inject_err,
    input  data, locked, err_sticky, err_count, first_err_xor
  );

  modport slave (
    input  enable, pause, load, ldata, chk_en, chk_valid, chk_data,
           clr_err, inject_err,
    output data, locked, err_sticky, err_count, first_err_xor
  );
endinterface

// File: rtl/ddr2_ex_lfsr_gen_chk.sv
// ---------------------------------------------------------------------------
// ddr2_ex_lfsr_gen_chk
// Galois LFSR pattern generator and self-synchronising checker for the DDR2
// example driver/checker datapath. One instance per byte lane or address
// field.
//   Generator mode (chk_en = 0): emits WIDTH-bit words, STEPS LFSR steps per
//   advance, with load/pause control.
//   Checker mode (chk_en = 1): locks onto the first non-zero received word,
//   then compares each valid word against the predicted sequence and keeps
//   sticky/count/first-difference error status.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      ddr2_ex_lfsr_gen_chk_if.slave (control, check data, status)
// Optional feature: define DDR2_EX_LFSR_ERR_INJECT_EN to enable inject_err
// (bit-0 flip of one generated word, or a forced miscompare in checking).
// Without it inject_err is ignored.
// ---------------------------------------------------------------------------
module ddr2_ex_lfsr_gen_chk #(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] TAPS      = 64'h1D,
  parameter logic [63:0] SEED      = 64'd32,
  parameter int          STEPS     = 1,
  parameter int          ERR_CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  ddr2_ex_lfsr_gen_chk_if.slave bus
);

  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GEN   = 2'd1;
  localparam logic [1:0] SYNC  = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  // One Galois step: shift up, msb always wraps into bit 0 and is XORed
  // into every higher bit selected by the feedback mask.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] fb;
    fb = {TAPS_W[WIDTH-1:1], 1'b1} & {WIDTH{cur[WIDTH-1]}};
    return {cur[WIDTH-2:0], 1'b0} ^ fb;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] v;
    v = cur;
    for (int s = 0; s < STEPS; s++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic                 locked_q, locked_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     fxor_q, fxor_d;
  logic                 gen_adv;
  logic                 chk_beat;
  logic                 miscmp;
  logic                 inj_chk;

  // Next-state: mode changes and disable take priority over any datapath
  // action in the same cycle.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    locked_d = locked_q;
    gen_adv  = 1'b0;
    chk_beat = 1'b0;
    if (!bus.enable) begin
      state_d  = IDLE;
      lfsr_d   = SEED_W;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = bus.chk_en ? SYNC : GEN;
        GEN: begin
          if (bus.chk_en) begin
            state_d  = SYNC;
            locked_d = 1'b0;
          end else if (bus.load) begin
            // all-zero is the LFSR lock-up state, never load it
            lfsr_d = (bus.ldata == '0) ? SEED_W : bus.ldata;
          end else if (!bus.pause) begin
            lfsr_d  = lfsr_advance(lfsr_q);
            gen_adv = 1'b1;
          end
        end
        SYNC: begin
          if (!bus.chk_en) begin
            state_d  = GEN;
            locked_d = 1'b0;
          end else if (bus.chk_valid && (bus.chk_data != '0)) begin
            // received word is taken as truth; predict the following one
            lfsr_d   = lfsr_advance(bus.chk_data);
            locked_d = 1'b1;
            state_d  = CHECK;
          end
        end
        default: begin
          if (!bus.chk_en) begin
            state_d  = GEN;
            locked_d = 1'b0;
          end else if (bus.chk_valid) begin
            chk_beat = 1'b1;
            lfsr_d   = lfsr_advance(lfsr_q);
          end
        end
      endcase
    end
  end

  assign miscmp = chk_beat & ((bus.chk_data != lfsr_q) | inj_chk);

  // Error status: clear wins over a same-cycle miscompare.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    fxor_d   = fxor_q;
    if (bus.clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      fxor_d   = '0;
    end else if (miscmp) begin
      sticky_d = 1'b1;
      cnt_d    = sat_inc(cnt_q);
      if (!sticky_q) fxor_d = bus.chk_data ^ lfsr_q;
    end
  end

  // Register stage: state, LFSR and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_W;
      locked_q <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      fxor_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      locked_q <= locked_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      fxor_q   <= fxor_d;
    end
  end

`ifdef DDR2_EX_LFSR_ERR_INJECT_EN
  // Separate output register so a flipped word never feeds back into the
  // LFSR: only the emitted word is corrupted.
  logic             inj_gen;
  logic [WIDTH-1:0] data_q;

  assign inj_gen = gen_adv & bus.inject_err;
  assign inj_chk = bus.inject_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= SEED_W;
    else          data_q <= lfsr_d ^ {{(WIDTH-1){1'b0}}, inj_gen};
  end

  assign bus.data = data_q;
`else
  logic unused_inject;
  logic unused_gen_adv;

  assign inj_chk        = 1'b0;
  assign unused_inject  = bus.inject_err;
  assign unused_gen_adv = gen_adv;
  assign bus.data       = lfsr_q;
`endif

  assign bus.locked        = locked_q;
  assign bus.err_sticky    = sticky_q;
  assign bus.err_count     = cnt_q;
  assign bus.first_err_xor = fxor_q;

endmodule

// File: tb/tb_ddr2_ex_lfsr_gen_chk.sv
// ---------------------------------------------------------------------------
// tb_ddr2_ex_lfsr_gen_chk
// Three instances driven by the same stimulus:
//   dut0 : defaults (STEPS=1, ERR_CNT_W=16)
//   dut1 : STEPS=2
//   dut2 : ERR_CNT_W=2
// Directed steps followed by a random phase, every cycle compared against a
// behavioural model that treats the LFSR as multiplication by x modulo the
// polynomial x^8+x^4+x^3+x^2+1.
// ---------------------------------------------------------------------------
module tb_ddr2_ex_lfsr_gen_chk;

`ifdef DDR2_EX_LFSR_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_GEN   = 1;
  localparam int PH_SYNC  = 2;
  localparam int PH_CHECK = 3;
  localparam int SEED     = 'h20;
  localparam int POLY     = 'h11D;

  logic       clk;
  logic       reset_n;
  logic       enable, pause, load, chk_en, chk_valid, clr_err, inject_err;
  logic [7:0] ldata, chk_data;

  int checks   = 0;
  int failures = 0;

  ddr2_ex_lfsr_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(16)) if0 ();
  ddr2_ex_lfsr_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(16)) if1 ();
  ddr2_ex_lfsr_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(2))  if2 ();

  assign if0.enable = enable;    assign if1.enable = enable;    assign if2.enable = enable;
  assign if0.pause = pause;      assign if1.pause = pause;      assign if2.pause = pause;
  assign if0.load = load;        assign if1.load = load;        assign if2.load = load;
  assign if0.ldata = ldata;      assign if1.ldata = ldata;      assign if2.ldata = ldata;
  assign if0.chk_en = chk_en;    assign if1.chk_en = chk_en;    assign if2.chk_en = chk_en;
  assign if0.chk_valid = chk_valid;
  assign if1.chk_valid = chk_valid;
  assign if2.chk_valid = chk_valid;
  assign if0.chk_data = chk_data; assign if1.chk_data = chk_data; assign if2.chk_data = chk_data;
  assign if0.clr_err = clr_err;  assign if1.clr_err = clr_err;  assign if2.clr_err = clr_err;
  assign if0.inject_err = inject_err;
  assign if1.inject_err = inject_err;
  assign if2.inject_err = inject_err;

  ddr2_ex_lfsr_gen_chk #(.WIDTH(8), .TAPS(64'h1D), .SEED(64'd32), .STEPS(1), .ERR_CNT_W(16))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  ddr2_ex_lfsr_gen_chk #(.WIDTH(8), .TAPS(64'h1D), .SEED(64'd32), .STEPS(2), .ERR_CNT_W(16))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  ddr2_ex_lfsr_gen_chk #(.WIDTH(8), .TAPS(64'h1D), .SEED(64'd32), .STEPS(1), .ERR_CNT_W(2))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_steps [3] = '{1, 2, 1};
  int m_cmax  [3] = '{65535, 65535, 3};
  int m_ph    [3];
  int m_w     [3];
  int m_out   [3];
  int m_locked[3];
  int m_sticky[3];
  int m_cnt   [3];
  int m_fx    [3];

  // multiply by x in GF(2)[x]/POLY, n times
  function automatic int m_adv(input int w, input int n);
    int v;
    v = w;
    for (int i = 0; i < n; i++) begin
      v = v << 1;
      if ((v & 'h100) != 0) v = v ^ POLY;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = PH_IDLE; m_w[k] = SEED; m_out[k] = SEED; m_locked[k] = 0;
      m_sticky[k] = 0; m_cnt[k] = 0; m_fx[k] = 0;
    end
  endtask

  task automatic model_tick();
    for (int k = 0; k < 3; k++) begin
      int w0;
      bit mis;
      bit flip;
      w0 = m_w[k]; mis = 0; flip = 0;
      if (!enable) begin
        m_ph[k] = PH_IDLE; m_w[k] = SEED; m_locked[k] = 0;
      end else if (m_ph[k] == PH_IDLE) begin
        m_ph[k] = chk_en ? PH_SYNC : PH_GEN;
      end else if ((m_ph[k] == PH_GEN) == chk_en) begin
        m_ph[k] = chk_en ? PH_SYNC : PH_GEN;
        m_locked[k] = 0;
      end else if (m_ph[k] == PH_GEN) begin
        if (load) m_w[k] = (ldata != 0) ? int'(ldata) : SEED;
        else if (!pause) begin
          m_w[k] = m_adv(w0, m_steps[k]);
          flip = INJ && inject_err;
        end
      end else if (m_ph[k] == PH_SYNC) begin
        if (chk_valid && chk_data != 0) begin
          m_w[k] = m_adv(int'(chk_data), m_steps[k]);
          m_locked[k] = 1;
          m_ph[k] = PH_CHECK;
        end
      end else if (chk_valid) begin
        mis = (int'(chk_data) != w0) || (INJ && inject_err);
        m_w[k] = m_adv(w0, m_steps[k]);
      end
      if (clr_err) begin
        m_sticky[k] = 0; m_cnt[k] = 0; m_fx[k] = 0;
      end else if (mis) begin
        if (m_sticky[k] == 0) m_fx[k] = int'(chk_data) ^ w0;
        m_sticky[k] = 1;
        if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end
      m_out[k] = flip ? (m_w[k] ^ 1) : m_w[k];
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int k, input logic [63:0] d, input logic l, input logic s,
                         input logic [63:0] c, input logic [63:0] f);
    chk($sformatf("dut%0d_data", k),   d, 64'(m_out[k]));
    chk($sformatf("dut%0d_locked", k), 64'(l), 64'(m_locked[k]));
    chk($sformatf("dut%0d_sticky", k), 64'(s), 64'(m_sticky[k]));
    chk($sformatf("dut%0d_count", k),  c, 64'(m_cnt[k]));
    chk($sformatf("dut%0d_fxor", k),   f, 64'(m_fx[k]));
  endtask

  task automatic check_all();
    chk_dut(0, 64'(if0.data), if0.locked, if0.err_sticky, 64'(if0.err_count), 64'(if0.first_err_xor));
    chk_dut(1, 64'(if1.data), if1.locked, if1.err_sticky, 64'(if1.err_count), 64'(if1.first_err_xor));
    chk_dut(2, 64'(if2.data), if2.locked, if2.err_sticky, 64'(if2.err_count), 64'(if2.first_err_xor));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    enable = 0; pause = 0; load = 0; ldata = 0; chk_en = 0;
    chk_valid = 0; chk_data = 0; clr_err = 0; inject_err = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("rst_data", 64'(if0.data), 64'h20);

    @(posedge clk); #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // free-running generator sequences
    cyc(); chk("gen_s1_c1", 64'(if0.data), 64'h20); chk("gen_s2_c1", 64'(if1.data), 64'h20);
    cyc(); chk("gen_s1_c2", 64'(if0.data), 64'h40); chk("gen_s2_c2", 64'(if1.data), 64'h80);
    cyc(); chk("gen_s1_c3", 64'(if0.data), 64'h80); chk("gen_s2_c3", 64'(if1.data), 64'h3A);
    cyc(); chk("gen_s1_c4", 64'(if0.data), 64'h1D);
    cyc(); chk("gen_s1_c5", 64'(if0.data), 64'h3A);

    // load of zero falls back to SEED, then pause holds
    load = 1; ldata = 8'h00;
    cyc(); chk("load_zero", 64'(if0.data), 64'h20);
    load = 0; pause = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk($sformatf("pause_%0d", i), 64'(if0.data), 64'h20);
    end
    pause = 0;
    cyc(); chk("pause_release", 64'(if0.data), 64'h40);

    // checker: sync, lock, clean compares
    chk_en = 1;
    cyc();
    chk_valid = 1; chk_data = 8'h00;
    cyc(); chk("sync_zero_ignored", 64'(if0.locked), 64'h0);
    chk_data = 8'h80;
    cyc(); chk("lock_locked", 64'(if0.locked), 64'h1); chk("lock_data", 64'(if0.data), 64'h1D);
    chk_data = 8'h1D; cyc();
    chk_data = 8'h3A; cyc(); chk("clean_count", 64'(if0.err_count), 64'h0);

    // miscompares and clear
    chk_data = 8'h11;
    cyc();
    chk("bad1_sticky", 64'(if0.err_sticky), 64'h1);
    chk("bad1_count", 64'(if0.err_count), 64'h1);
    chk("bad1_fxor", 64'(if0.first_err_xor), 64'h65);
    chk_data = 8'h00;
    cyc();
    chk("bad2_count", 64'(if0.err_count), 64'h2);
    chk("bad2_fxor", 64'(if0.first_err_xor), 64'h65);
    chk_valid = 0; clr_err = 1;
    cyc();
    chk("clr_sticky", 64'(if0.err_sticky), 64'h0);
    chk("clr_count", 64'(if0.err_count), 64'h0);
    chk("clr_fxor", 64'(if0.first_err_xor), 64'h0);

    // counter saturation on the narrow instance
    clr_err = 0; chk_valid = 1; chk_data = 8'h00;
    for (int i = 0; i < 5; i++) cyc();
    chk("sat_narrow", 64'(if2.err_count), 64'h3);
    chk("sat_wide", 64'(if0.err_count), 64'h5);

    // random phase
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom % 16) != 0;
      pause      = ($urandom % 4) == 0;
      load       = ($urandom % 8) == 0;
      ldata      = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      if (($urandom % 20) == 0) chk_en = ~chk_en;
      chk_valid  = ($urandom % 2) == 0;
      chk_data   = (($urandom % 4) != 0) ? 8'(m_out[0]) : 8'($urandom);
      clr_err    = ($urandom % 32) == 0;
      inject_err = ($urandom % 8) == 0;
      cyc();
    end

    // asynchronous reset while checking
    enable = 1; chk_en = 1; pause = 0; load = 0; clr_err = 0; inject_err = 0; chk_valid = 0;
    cyc(); cyc();
    chk_valid = 1; chk_data = 8'h80;
    cyc();
    chk_data = 8'h00;
    cyc();
    chk("pre_rst_locked", 64'(if0.locked), 64'h1);
    chk("pre_rst_sticky", 64'(if0.err_sticky), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_data", 64'(if0.data), 64'h20);
    chk("async_rst_locked", 64'(if0.locked), 64'h0);
    chk("async_rst_count", 64'(if0.err_count), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
